cache_refill_ctrl: RTL and testbench

- Miss-handling stage directly upstream of the direct-mapped cache memory.
- On a cache miss, fetches the full 4-word block from main memory one word at a time and assembles it into the 128-bit fill block that the cache writes into the missed line.
- Stalls the requester until the fill completes.
- Sits between the cache miss output and the main-memory read port.

---
 rtl/cache_pkg.sv | 19 +
 rtl/cache_refill_ctrl_assembler.sv | 68 ++++++
 rtl/cache_refill_ctrl.sv | 144 ++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache refill controller.
//   - refill_state_t : refill FSM states (idle, fetching words, fill handoff)
//   - WORD_LEN, ADDR_LEN, WORDS_PER_BLOCK, BLOCK_DATA_LEN : datapath geometry
//   - OFFSET_LEN : width of the word-offset field inside a word address
package cache_pkg;

    localparam int unsigned WORD_LEN        = 32;
    localparam int unsigned ADDR_LEN        = 15;
    localparam int unsigned WORDS_PER_BLOCK = 4;
    localparam int unsigned BLOCK_DATA_LEN  = WORDS_PER_BLOCK * WORD_LEN;
    localparam int unsigned OFFSET_LEN      = 2;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDone
    } refill_state_t;

endpackage

// File: rtl/cache_refill_ctrl_assembler.sv
// refill_block_assembler: word-slot counter plus the fill block register.
// The counter selects which block slot the next accepted memory word lands in
// and wraps modulo 4, so a fetch starting mid-block fills the remaining slots
// in wrapped order. Slots not yet written keep their previous contents.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (clears counter and slots)
//   load        : load the counter with start_off (start of a refill)
//   start_off   : first word offset of the refill
//   accept      : a memory word is accepted this cycle; write slot ctr, advance
//   wdata       : word to write
//   ctr         : current slot / word offset
//   block_data  : packed slots, slot k at bits [k*WORD_LEN +: WORD_LEN]
module refill_block_assembler #(
    parameter int unsigned WORD_LEN        = 32,
    parameter int unsigned WORDS_PER_BLOCK = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                load,
    input  logic [1:0]                          start_off,
    input  logic                                accept,
    input  logic [WORD_LEN-1:0]                 wdata,
    output logic [1:0]                          ctr,
    output logic [WORDS_PER_BLOCK*WORD_LEN-1:0] block_data
);
    import cache_pkg::*;

    logic [OFFSET_LEN-1:0] ctr_q, ctr_d;
    logic [WORD_LEN-1:0]   words_q [WORDS_PER_BLOCK];
    logic [WORD_LEN-1:0]   words_d [WORDS_PER_BLOCK];

    always_comb begin
        ctr_d = ctr_q;
        for (int k = 0; k < int'(WORDS_PER_BLOCK); k++) begin
            words_d[k] = words_q[k];
        end
        if (load) begin
            ctr_d = start_off;
        end else if (accept) begin
            words_d[ctr_q] = wdata;
            ctr_d          = ctr_q + 2'd1;  // 2-bit wrap gives the modulo-4 order
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctr_q <= '0;
            for (int k = 0; k < int'(WORDS_PER_BLOCK); k++) begin
                words_q[k] <= '0;
            end
        end else begin
            ctr_q <= ctr_d;
            for (int k = 0; k < int'(WORDS_PER_BLOCK); k++) begin
                words_q[k] <= words_d[k];
            end
        end
    end

    always_comb begin
        block_data = '0;
        for (int k = 0; k < int'(WORDS_PER_BLOCK); k++) begin
            block_data[k*WORD_LEN +: WORD_LEN] = words_q[k];
        end
    end

    assign ctr = ctr_q;

endmodule

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: cache miss refill controller.
// On a miss, reads the 4-word block from main memory one word at a time,
// assembles the 128-bit fill block, pulses fill_valid for one cycle and
// stalls the requester from the first fetch cycle through the fill cycle.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   miss_req, address : level miss request and missing word address
//   mem_rd, mem_addr  : memory read request and word address
//   mem_rdata, mem_ready : memory read data and its valid strobe
//   block_data, fill_addr, fill_valid : assembled block, base address, pulse
//   stall             : high whenever the controller is not idle
//   early_word, early_word_valid : critical word, registered one-cycle pulse
// Build option: CACHE_REFILL_CRITICAL_WORD_FIRST_EN starts the fetch at the
// missing word and reports it early; without it the fetch starts at word 0
// and the early-word outputs are tied low.
module cache_refill_ctrl #(
    parameter int unsigned WORD_LEN        = 32,
    parameter int unsigned ADDR_LEN        = 15,
    parameter int unsigned WORDS_PER_BLOCK = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                miss_req,
    input  logic [ADDR_LEN-1:0]                 address,
    output logic                                mem_rd,
    output logic [ADDR_LEN-1:0]                 mem_addr,
    input  logic [WORD_LEN-1:0]                 mem_rdata,
    input  logic                                mem_ready,
    output logic [WORDS_PER_BLOCK*WORD_LEN-1:0] block_data,
    output logic [ADDR_LEN-1:0]                 fill_addr,
    output logic                                fill_valid,
    output logic                                stall,
    output logic [WORD_LEN-1:0]                 early_word,
    output logic                                early_word_valid
);
    import cache_pkg::*;

    refill_state_t         state_q, state_d;
    logic [ADDR_LEN-1:0]   base_q, base_d;
    // Accepted-word count; separate from the slot counter because the slot
    // counter may start mid-block.
    logic [OFFSET_LEN-1:0] cnt_q, cnt_d;
    logic                  load;
    logic                  accept;
    logic [OFFSET_LEN-1:0] start_off;
    logic [OFFSET_LEN-1:0] ctr;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (miss_req) begin
                    base_d  = {address[ADDR_LEN-1:OFFSET_LEN], {OFFSET_LEN{1'b0}}};
                    cnt_d   = '0;
                    load    = 1'b1;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (mem_ready) begin
                    accept = 1'b1;
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            base_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
        end
    end

    refill_block_assembler #(
        .WORD_LEN        (WORD_LEN),
        .WORDS_PER_BLOCK (WORDS_PER_BLOCK)
    ) u_assembler (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .start_off  (start_off),
        .accept     (accept),
        .wdata      (mem_rdata),
        .ctr        (ctr),
        .block_data (block_data)
    );

    assign mem_rd     = (state_q == StFetch);
    assign mem_addr   = mem_rd ? {base_q[ADDR_LEN-1:OFFSET_LEN], ctr} : '0;
    assign fill_addr  = base_q;
    assign fill_valid = (state_q == StDone);
    assign stall      = (state_q != StIdle);

`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
    logic [WORD_LEN-1:0] early_word_q;
    logic                early_valid_q;
    logic                first_accept;

    assign start_off    = address[OFFSET_LEN-1:0];
    assign first_accept = accept && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            early_word_q  <= '0;
            early_valid_q <= 1'b0;
        end else begin
            early_valid_q <= first_accept;
            if (first_accept) begin
                early_word_q <= mem_rdata;
            end
        end
    end

    assign early_word       = early_word_q;
    assign early_word_valid = early_valid_q;
`else
    // Offset bits only matter when the fetch starts at the missing word.
    logic unused_offset;
    assign unused_offset    = ^address[OFFSET_LEN-1:0];
    assign start_off        = '0;
    assign early_word       = '0;
    assign early_word_valid = 1'b0;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
module tb_cache_refill_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         miss_req = 1'b0;
    logic [14:0]  address = '0;
    logic         mem_rd;
    logic [14:0]  mem_addr;
    logic [31:0]  mem_rdata = '0;
    logic         mem_ready = 1'b0;
    logic [127:0] block_data;
    logic [14:0]  fill_addr;
    logic         fill_valid;
    logic         stall;
    logic [31:0]  early_word;
    logic         early_word_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_refill_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .miss_req         (miss_req),
        .address          (address),
        .mem_rd           (mem_rd),
        .mem_addr         (mem_addr),
        .mem_rdata        (mem_rdata),
        .mem_ready        (mem_ready),
        .block_data       (block_data),
        .fill_addr        (fill_addr),
        .fill_valid       (fill_valid),
        .stall            (stall),
        .early_word       (early_word),
        .early_word_valid (early_word_valid)
    );

`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
    localparam bit Cwf = 1'b1;
`else
    localparam bit Cwf = 1'b0;
`endif

    // Reference model: a refill is a queue of word offsets still to fetch,
    // followed by one fill-handoff cycle.
    int           m_q[$];
    bit           m_done = 1'b0;
    logic [14:0]  m_base = '0;
    logic [127:0] m_block = '0;
    logic [31:0]  m_ew = '0;
    bit           m_ewv = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_update();
        bit first_acc;
        int start;
        first_acc = 1'b0;
        if (rst) begin
            m_q.delete();
            m_done  = 1'b0;
            m_base  = '0;
            m_block = '0;
            m_ew    = '0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_q.size() > 0) begin
            if (mem_ready) begin
                first_acc = (m_q.size() == 4);
                m_block[m_q[0]*32 +: 32] = mem_rdata;
                if (first_acc && Cwf) m_ew = mem_rdata;
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_done = 1'b1;
            end
        end else if (miss_req) begin
            m_base = address & 15'h7ffc;
            start  = Cwf ? int'(address % 4) : 0;
            for (int i = 0; i < 4; i++) m_q.push_back((start + i) % 4);
        end
        m_ewv = Cwf && first_acc && !rst;
    endtask

    task automatic check_model();
        logic        e_rd;
        logic [14:0] e_addr;
        e_rd   = (m_q.size() > 0);
        e_addr = e_rd ? m_base + 15'(m_q[0]) : 15'h0;
        chk("mem_rd", 128'(mem_rd), 128'(e_rd));
        chk("mem_addr", 128'(mem_addr), 128'(e_addr));
        chk("fill_valid", 128'(fill_valid), 128'(m_done));
        chk("stall", 128'(stall), 128'(e_rd || m_done));
        chk("fill_addr", 128'(fill_addr), 128'(m_base));
        chk("block_data", block_data, m_block);
        chk("early_word", 128'(early_word), 128'(m_ew));
        chk("early_word_valid", 128'(early_word_valid), 128'(m_ewv));
    endtask

    // One clock cycle: inputs already driven; check at negedge, advance model.
    task automatic step();
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive_mem();
        mem_rdata = 32'hA0 + 32'(mem_addr);
    endtask

    // Run with mem_ready=1 until idle, bounded.
    task automatic drain();
        int n;
        n = 0;
        miss_req  = 1'b0;
        mem_ready = 1'b1;
        while (stall && n < 20) begin
            drive_mem();
            step();
            n++;
        end
        chk("drain_bound", 128'(stall), 128'(0));
    endtask

    typedef struct {
        logic        miss;
        logic [14:0] addr;
        logic        ready;
        logic [31:0] rdata;
        logic        e_rd;
        logic [14:0] e_addr;
        logic        e_fv;
        logic        e_stall;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int k, fill_k, pulses, gaps;
        logic [14:0] exp_order[4];

        tbl[0] = '{1'b1, 15'h124, 1'b1, 32'h0,   1'b0, 15'h0,   1'b0, 1'b0};
        tbl[1] = '{1'b0, 15'h124, 1'b1, 32'h1C4, 1'b1, 15'h124, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 15'h124, 1'b1, 32'h1C5, 1'b1, 15'h125, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 15'h124, 1'b1, 32'h1C6, 1'b1, 15'h126, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 15'h124, 1'b1, 32'h1C7, 1'b1, 15'h127, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 15'h124, 1'b1, 32'h0,   1'b0, 15'h0,   1'b1, 1'b1};
        tbl[6] = '{1'b0, 15'h124, 1'b0, 32'h0,   1'b0, 15'h0,   1'b0, 1'b0};

        // Reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        model_update();
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_model();
        chk("reset_stall", 128'(stall), 128'(0));
        chk("reset_block", block_data, 128'(0));
        @(posedge clk);
        model_update();
        #1;

        // Basic fill, table driven
        for (int i = 0; i < 7; i++) begin
            miss_req  = tbl[i].miss;
            address   = tbl[i].addr;
            mem_ready = tbl[i].ready;
            mem_rdata = tbl[i].rdata;
            @(negedge clk);
            check_model();
            chk($sformatf("tbl%0d_mem_rd", i), 128'(mem_rd), 128'(tbl[i].e_rd));
            chk($sformatf("tbl%0d_mem_addr", i), 128'(mem_addr), 128'(tbl[i].e_addr));
            chk($sformatf("tbl%0d_fill_valid", i), 128'(fill_valid), 128'(tbl[i].e_fv));
            chk($sformatf("tbl%0d_stall", i), 128'(stall), 128'(tbl[i].e_stall));
            @(posedge clk);
            model_update();
            #1;
        end
        chk("basic_block", block_data, {32'h1C7, 32'h1C6, 32'h1C5, 32'h1C4});
        chk("basic_fill_addr", 128'(fill_addr), 128'(15'h124));

        // Wait states: ready every 3rd fetch cycle
        miss_req = 1'b1; address = 15'h124; mem_ready = 1'b0;
        step();
        miss_req = 1'b0;
        k = 0; fill_k = -1; pulses = 0; gaps = 0;
        while (k < 40 && !(pulses > 0 && !stall)) begin
            if (fill_valid) begin
                pulses++;
                if (fill_k < 0) fill_k = k;
            end
            if (!stall) gaps++;
            mem_ready = (k % 3 == 2);
            drive_mem();
            step();
            k++;
        end
        chk("wait_fill_cycle", 128'(fill_k), 128'(12));
        chk("wait_fill_pulses", 128'(pulses), 128'(1));
        chk("wait_stall_gaps", 128'(gaps), 128'(0));

        // Ignored request while fetching
        miss_req = 1'b1; address = 15'h124; mem_ready = 1'b1;
        step();
        miss_req = 1'b0; drive_mem(); step();
        miss_req = 1'b1; address = 15'h200; drive_mem(); step();
        drive_mem(); step();
        miss_req = 1'b0;
        pulses = 0; k = 0;
        while (stall && k < 20) begin
            if (fill_valid) pulses++;
            drive_mem(); step(); k++;
        end
        chk("ignored_fill_addr", 128'(fill_addr), 128'(15'h124));
        chk("ignored_pulses", 128'(pulses), 128'(1));

        // Reset mid-fetch after two accepted words
        miss_req = 1'b1; address = 15'h124; mem_ready = 1'b1;
        step();
        miss_req = 1'b0;
        drive_mem(); step();
        drive_mem(); step();
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_mid_stall", 128'(stall), 128'(0));
        chk("rst_mid_fill_valid", 128'(fill_valid), 128'(0));
        chk("rst_mid_mem_rd", 128'(mem_rd), 128'(0));
        chk("rst_mid_block", block_data, 128'(0));
        chk("rst_mid_fill_addr", 128'(fill_addr), 128'(0));
        miss_req = 1'b1; address = 15'h124;
        step();
        chk("rst_refetch_addr", 128'(mem_addr), 128'(15'h124));
        drain();

        // Back-to-back misses
        miss_req = 1'b1; address = 15'h124; mem_ready = 1'b1;
        step();
        address = 15'h308;
        k = 0;
        while (!fill_valid && k < 10) begin
            drive_mem(); step(); k++;
        end
        chk("b2b_fill_seen", 128'(fill_valid), 128'(1));
        step();
        chk("b2b_idle_cycle", 128'(stall), 128'(0));
        step();
        chk("b2b_mem_rd", 128'(mem_rd), 128'(1));
        chk("b2b_mem_addr", 128'(mem_addr), 128'(15'h308));
        drain();

        // Critical word first (order depends on build)
        if (Cwf) begin
            exp_order[0] = 15'h126; exp_order[1] = 15'h127;
            exp_order[2] = 15'h124; exp_order[3] = 15'h125;
        end else begin
            exp_order[0] = 15'h124; exp_order[1] = 15'h125;
            exp_order[2] = 15'h126; exp_order[3] = 15'h127;
        end
        miss_req = 1'b1; address = 15'h126; mem_ready = 1'b1;
        step();
        miss_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("cwf_order%0d", i), 128'(mem_addr), 128'(exp_order[i]));
            drive_mem();
            step();
            if (i == 0) begin
                chk("cwf_early_valid", 128'(early_word_valid), 128'(Cwf));
                chk("cwf_early_word", 128'(early_word), Cwf ? 128'(32'h1C6) : 128'(0));
            end
        end
        chk("cwf_fill_valid", 128'(fill_valid), 128'(1));
        chk("cwf_block", block_data, {32'h1C7, 32'h1C6, 32'h1C5, 32'h1C4});
        step();

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            rst       = ($urandom_range(0, 59) == 0);
            miss_req  = ($urandom_range(0, 2) == 0);
            address   = 15'($urandom);
            mem_ready = $urandom_range(0, 1) == 1;
            mem_rdata = $urandom;
            step();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
